// File: rtl/conv_pkg.sv
// Shared types and constants for the punctured convolutional encoder.
// Mode encodings, FSM states, default generators and puncture patterns.
// Pattern rows are written with puncture index 0 in the MSB, padded with zeros.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_R12 = 2'b00,
        MODE_R23 = 2'b01,
        MODE_R34 = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_e;

    // Industry-standard K=7 generators, MSB taps the newest bit
    localparam logic [6:0] G0_133 = 7'b1011011;
    localparam logic [6:0] G1_171 = 7'b1111001;

    // Puncture rows, index 0 at bit 2
    localparam logic [2:0] PAT_A_R12 = 3'b100;
    localparam logic [2:0] PAT_B_R12 = 3'b100;
    localparam logic [2:0] PAT_A_R23 = 3'b110;
    localparam logic [2:0] PAT_B_R23 = 3'b100;
    localparam logic [2:0] PAT_A_R34 = 3'b110;
    localparam logic [2:0] PAT_B_R34 = 3'b101;

    localparam logic [1:0] PERIOD_R12 = 2'd1;
    localparam logic [1:0] PERIOD_R23 = 2'd2;
    localparam logic [1:0] PERIOD_R34 = 2'd3;

    // The reserved encoding 11 runs as rate 1/2
    function automatic mode_e norm_mode(input logic [1:0] m);
        mode_e r;
        case (m)
            2'b01:   r = MODE_R23;
            2'b10:   r = MODE_R34;
            default: r = MODE_R12;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] punct_period(input mode_e m);
        logic [1:0] p;
        case (m)
            MODE_R23: p = PERIOD_R23;
            MODE_R34: p = PERIOD_R34;
            default:  p = PERIOD_R12;
        endcase
        return p;
    endfunction

    // Returns {A kept, B kept} for the given puncture index
    function automatic logic [1:0] punct_mask(input mode_e m, input logic [1:0] idx);
        logic [2:0] row_a;
        logic [2:0] row_b;
        logic [1:0] mask;
        row_a = PAT_A_R12;
        row_b = PAT_B_R12;
        case (m)
            MODE_R23: begin row_a = PAT_A_R23; row_b = PAT_B_R23; end
            MODE_R34: begin row_a = PAT_A_R34; row_b = PAT_B_R34; end
            default: ;
        endcase
        case (idx)
            2'd0:    mask = {row_a[2], row_b[2]};
            2'd1:    mask = {row_a[1], row_b[1]};
            default: mask = {row_a[0], row_b[0]};
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/conv_puncturer.sv
// Puncture mask lookup and puncture-index advance for one encoded step.
// Latency: combinational; the index register lives in the encoder top.
// Backpressure: none; only evaluates when the top signals a step.
module conv_puncturer
    import conv_pkg::*;
(
    input  logic       i_step,
    input  logic       i_start,
    input  mode_e      i_mode,
    input  logic [1:0] i_cnt,
    input  logic       i_a,
    input  logic       i_b,
    output logic [1:0] o_valid,
    output logic [1:0] o_ab,
    output logic [1:0] o_cnt_nxt
);

    logic [1:0] w_idx;
    logic [1:0] w_mask;
    logic [1:0] w_period;
    logic [1:0] w_idx_inc;

    // Pick the pattern column; a frame start always uses column 0
    always_comb begin
        w_idx     = i_start ? 2'd0 : i_cnt;
        w_mask    = punct_mask(i_mode, w_idx);
        w_period  = punct_period(i_mode);
        w_idx_inc = w_idx + 2'd1;
        o_valid   = 2'b00;
        o_ab      = 2'b00;
        o_cnt_nxt = i_cnt;
        if (i_step) begin
            o_valid   = w_mask;
            o_ab      = {i_a & w_mask[1], i_b & w_mask[0]};
            o_cnt_nxt = (w_idx_inc == w_period) ? 2'd0 : w_idx_inc;
        end
    end

endmodule

// File: rtl/punct_conv_encoder.sv
// Rate-1/2 convolutional encoder with run-time puncturing and K-1 zero-bit tail flush.
// Latency: 1 cycle from accepted bit (or tail step) to registered AB/valid_out.
// Backpressure: in_ready drops for the K-1 tail cycles; valid_in is ignored then.
module punct_conv_encoder
    import conv_pkg::*;
#(
    parameter int           K       = 7,
    parameter logic [K-1:0] G0      = G0_133,
    parameter logic [K-1:0] G1      = G1_171,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       in,
    input  logic       valid_in,
    input  logic       in_last,
    input  logic [1:0] mode,
    output logic       in_ready,
    output logic [1:0] AB,
    output logic [1:0] valid_out,
    output logic       out_last
);

    localparam int TW = $clog2(K);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [K-2:0]  r_sr;
    logic [TW-1:0] r_tail_cnt;
    logic [1:0]    r_cnt;
    mode_e         r_mode;
    logic [1:0]    r_ab;
    logic [1:0]    r_valid;
    logic          r_last;

    logic          w_in_ready;
    logic          w_tail_step;
    logic          w_accept;
    logic          w_start;
    logic          w_tail_done;
    logic          w_step;
    logic          w_in_eff;
    logic          w_last;
    mode_e         w_mode;
    logic [K-1:0]  w_win;
    logic          w_a;
    logic          w_b;
    logic [1:0]    w_valid;
    logic [1:0]    w_ab_p;
    logic [1:0]    w_cnt_nxt;

    // FSM state register
    always_ff @(posedge Clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: frames enter TAIL (or go straight back to IDLE without flush)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DATA: begin
                if (w_accept) begin
                    if (in_last) w_state_nxt = TAIL_EN ? TAIL : IDLE;
                    else         w_state_nxt = DATA;
                end
            end
            TAIL:    if (w_tail_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM outputs and the per-cycle step controls derived from them
    always_comb begin
        w_in_ready  = 1'b1;
        w_tail_step = 1'b0;
        if (r_state == TAIL) begin
            w_in_ready  = 1'b0;
            w_tail_step = 1'b1;
        end
        w_accept    = valid_in & w_in_ready;
        w_start     = w_accept & (r_state == IDLE);
        w_tail_done = w_tail_step & (r_tail_cnt == TW'(1));
        w_step      = w_accept | w_tail_step;
        w_in_eff    = w_accept & in;
        w_mode      = w_start ? norm_mode(mode) : r_mode;
        w_last      = (w_accept & in_last & ~TAIL_EN) | w_tail_done;
    end

    assign w_win = {w_in_eff, r_sr};
    assign w_a   = ^(w_win & G0);
    assign w_b   = ^(w_win & G1);

    conv_puncturer u_punct (
        .i_step    (w_step),
        .i_start   (w_start),
        .i_mode    (w_mode),
        .i_cnt     (r_cnt),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_valid   (w_valid),
        .o_ab      (w_ab_p),
        .o_cnt_nxt (w_cnt_nxt)
    );

    // Shift register advances on every encoded bit; mode is frozen at frame start
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_sr   <= '0;
            r_mode <= MODE_R12;
        end else begin
            if (w_step)  r_sr   <= w_win[K-1:1];
            if (w_start) r_mode <= w_mode;
        end
    end

    // Puncture index; the puncturer holds it when nothing is encoded
    always_ff @(posedge Clk) begin
        if (reset) r_cnt <= 2'd0;
        else       r_cnt <= w_cnt_nxt;
    end

    // Tail counter loads on the frame's last bit and counts down the flush
    always_ff @(posedge Clk) begin
        if (reset)                                 r_tail_cnt <= '0;
        else if (w_accept & in_last & TAIL_EN)     r_tail_cnt <= TW'(K - 1);
        else if (w_tail_step)                      r_tail_cnt <= r_tail_cnt - TW'(1);
    end

    // Registered outputs; AB holds across idle cycles
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_ab    <= 2'b00;
            r_valid <= 2'b00;
            r_last  <= 1'b0;
        end else begin
            r_valid <= w_valid;
            r_last  <= w_last;
            if (w_step) r_ab <= w_ab_p;
        end
    end

    assign in_ready  = w_in_ready;
    assign AB        = r_ab;
    assign valid_out = r_valid;
    assign out_last  = r_last;

endmodule

// File: tb/tb_punct_conv_encoder.sv
// Bench for punct_conv_encoder with a frame-level reference model.
// Model encodes each frame as a bit list with plain convolution sums and pattern strings.
// Captured outputs are {out_last, valid_out, AB masked by valid_out}.
`timescale 1ns/1ps
module tb_punct_conv_encoder;

    localparam int         K  = 7;
    localparam logic [6:0] G0 = 7'b1011011;
    localparam logic [6:0] G1 = 7'b1111001;

    logic       Clk = 1'b0;
    logic       reset;
    logic       in;
    logic       valid_in;
    logic       in_last;
    logic [1:0] mode;
    logic       in_ready;
    logic [1:0] AB;
    logic [1:0] valid_out;
    logic       out_last;

    int n_vec = 0;
    int n_err = 0;
    int ready_low = 0;
    logic [4:0] cap_q[$];
    logic [4:0] exp_q[$];

    punct_conv_encoder dut (
        .Clk       (Clk),
        .reset     (reset),
        .in        (in),
        .valid_in  (valid_in),
        .in_last   (in_last),
        .mode      (mode),
        .in_ready  (in_ready),
        .AB        (AB),
        .valid_out (valid_out),
        .out_last  (out_last)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (valid_out != 2'b00) cap_q.push_back({out_last, valid_out, AB & valid_out});
        if (in_ready === 1'b0) ready_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: frame bits followed by K-1 zeros, each step a convolution sum, punctured by strings
    task automatic model_frame(input logic bits[$], input logic [1:0] m);
        logic x[$];
        string pa, pb;
        int per;
        logic a, b, va, vb, last;
        x = bits;
        for (int i = 0; i < K - 1; i++) x.push_back(1'b0);
        case (m)
            2'b01:   begin pa = "11";  pb = "10";  end
            2'b10:   begin pa = "110"; pb = "101"; end
            default: begin pa = "1";   pb = "1";   end
        endcase
        per = pa.len();
        for (int t = 0; t < x.size(); t++) begin
            a = 1'b0;
            b = 1'b0;
            for (int j = 0; j < K; j++) begin
                if (t - j >= 0) begin
                    a = a ^ (G0[K-1-j] & x[t-j]);
                    b = b ^ (G1[K-1-j] & x[t-j]);
                end
            end
            va   = (pa.substr(t % per, t % per) == "1");
            vb   = (pb.substr(t % per, t % per) == "1");
            last = (t == x.size() - 1);
            exp_q.push_back({last, va, vb, a & va, b & vb});
        end
    endtask

    task automatic drive_frame(input logic bits[$], input logic [1:0] m, input bit toggle_mode,
                               input int gap_pct, input bit keep_valid);
        int guard;
        for (int i = 0; i < bits.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                valid_in = 1'b0;
                mode     = 2'($urandom);
                @(posedge Clk); #1;
            end
            valid_in = 1'b1;
            in       = bits[i];
            in_last  = (i == bits.size() - 1);
            mode     = (i == 0 || !toggle_mode) ? m : 2'($urandom);
            guard    = 0;
            @(negedge Clk);
            while (in_ready !== 1'b1 && guard < 100) begin
                @(negedge Clk);
                guard++;
            end
            @(posedge Clk); #1;
        end
        if (!keep_valid) begin
            valid_in = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        int guard;
        guard = 0;
        while (cap_q.size() < n && guard < 500) begin
            @(posedge Clk);
            guard++;
        end
        repeat (12) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; in = 1'b0; in_last = 1'b0; mode = 2'b00;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++; if (valid_out !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", valid_out); end
        n_vec++; if (AB !== 2'b00)        begin n_err++; $display("FAIL reset_ab got %b want 00", AB); end
        n_vec++; if (out_last !== 1'b0)   begin n_err++; $display("FAIL reset_last got %b want 0", out_last); end
        n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL reset_ready got %b want 1", in_ready); end
        reset = 1'b0;
        @(posedge Clk); #1;
        cap_q.delete();
    endtask

    task automatic test_impulse();
        logic bits[$];
        logic [12:0] ea, eb;
        logic [4:0] e;
        ea = 13'b1011011000000;
        eb = 13'b1111001000000;
        cap_q.delete();
        bits.push_back(1'b1);
        repeat (6) bits.push_back(1'b0);
        drive_frame(bits, 2'b00, 1'b0, 0, 1'b0);
        drain(13);
        n_vec++;
        if (cap_q.size() != 13) begin n_err++; $display("FAIL impulse_count got %0d want 13", cap_q.size()); end
        for (int t = 0; t < 13 && t < cap_q.size(); t++) begin
            e = {(t == 12), 2'b11, ea[12-t], eb[12-t]};
            n_vec++;
            if (cap_q[t] !== e) begin n_err++; $display("FAIL impulse[%0d] got %b want %b", t, cap_q[t], e); end
        end
    endtask

    task automatic test_rate23();
        logic f1[$], f2[$];
        logic [1:0] ev;
        cap_q.delete(); exp_q.delete();
        f1.push_back(1'($urandom));
        for (int i = 0; i < 4; i++) f2.push_back(1'($urandom));
        model_frame(f1, 2'b01);
        model_frame(f2, 2'b01);
        drive_frame(f1, 2'b01, 1'b0, 0, 1'b0);
        drive_frame(f2, 2'b01, 1'b0, 0, 1'b0);
        drain(exp_q.size());
        n_vec++;
        if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL r23_count got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL r23[%0d] got %b want %b", i, cap_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 4 && (7 + i) < cap_q.size(); i++) begin
            ev = (i % 2 == 0) ? 2'b11 : 2'b10;
            n_vec++;
            if (cap_q[7+i][3:2] !== ev) begin n_err++; $display("FAIL r23_start_valid[%0d] got %b want %b", i, cap_q[7+i][3:2], ev); end
        end
    endtask

    task automatic test_rate34();
        logic f[$];
        logic [1:0] ev;
        int nbits;
        cap_q.delete(); exp_q.delete();
        for (int i = 0; i < 6; i++) f.push_back(1'($urandom));
        model_frame(f, 2'b10);
        drive_frame(f, 2'b10, 1'b0, 0, 1'b0);
        drain(exp_q.size());
        n_vec++;
        if (cap_q.size() != 12) begin n_err++; $display("FAIL r34_count got %0d want 12", cap_q.size()); end
        nbits = 0;
        for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
            ev = (i % 3 == 0) ? 2'b11 : ((i % 3 == 1) ? 2'b10 : 2'b01);
            nbits += cap_q[i][3] + cap_q[i][2];
            n_vec++;
            if (cap_q[i][3:2] !== ev) begin n_err++; $display("FAIL r34_valid[%0d] got %b want %b", i, cap_q[i][3:2], ev); end
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL r34[%0d] got %b want %b", i, cap_q[i], exp_q[i]); end
        end
        n_vec++;
        if (nbits != 16) begin n_err++; $display("FAIL r34_coded_bits got %0d want 16", nbits); end
    endtask

    task automatic test_handshake();
        logic f1[$], f2[$];
        int r0;
        cap_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) f1.push_back(1'($urandom));
        for (int i = 0; i < 4; i++) f2.push_back(1'($urandom));
        model_frame(f1, 2'b10);
        model_frame(f2, 2'b01);
        r0 = ready_low;
        drive_frame(f1, 2'b10, 1'b1, 0, 1'b1);
        drive_frame(f2, 2'b01, 1'b1, 0, 1'b0);
        drain(exp_q.size());
        n_vec++;
        if (ready_low - r0 != 2 * (K - 1)) begin n_err++; $display("FAIL hs_ready_low got %0d want %0d", ready_low - r0, 2 * (K - 1)); end
        n_vec++;
        if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL hs_count got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL hs[%0d] got %b want %b", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_tail();
        logic bits[$];
        int nlast;
        cap_q.delete(); exp_q.delete();
        bits.push_back(1'b1);
        repeat (6) bits.push_back(1'b0);
        drive_frame(bits, 2'b00, 1'b0, 0, 1'b0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        reset = 1'b1;
        @(posedge Clk); #1;
        n_vec++; if (valid_out !== 2'b00) begin n_err++; $display("FAIL rmt_valid got %b want 00", valid_out); end
        n_vec++; if (out_last !== 1'b0)   begin n_err++; $display("FAIL rmt_last got %b want 0", out_last); end
        n_vec++; if (in_ready !== 1'b1)   begin n_err++; $display("FAIL rmt_ready got %b want 1", in_ready); end
        reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        nlast = 0;
        foreach (cap_q[i]) nlast += cap_q[i][4];
        n_vec++;
        if (cap_q.size() != 9 || nlast != 0) begin n_err++; $display("FAIL rmt_aborted got %0d outputs %0d last want 9 outputs 0 last", cap_q.size(), nlast); end
        cap_q.delete();
        model_frame(bits, 2'b00);
        drive_frame(bits, 2'b00, 1'b0, 0, 1'b0);
        drain(exp_q.size());
        n_vec++;
        if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL rmt_count got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rmt_impulse[%0d] got %b want %b", i, cap_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic f[$];
        logic [1:0] m;
        int total, len;
        cap_q.delete(); exp_q.delete();
        total = 0;
        while (total < 1000) begin
            len = $urandom_range(40, 1);
            m   = 2'($urandom);
            f.delete();
            for (int i = 0; i < len; i++) f.push_back(1'($urandom));
            model_frame(f, m);
            drive_frame(f, m, 1'b1, 30, 1'b0);
            total += len;
        end
        drain(exp_q.size());
        n_vec++;
        if (cap_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", cap_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_vec++;
            if (cap_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand[%0d] got %b want %b", i, cap_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_rate23();
        test_rate34();
        test_handshake();
        test_reset_mid_tail();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
